// File: rtl/mem_pipe.sv
// mem_pipe: MEM stage of the 5-stage MIPS pipeline (data-memory req/ack access, timeout, M/W register).
// Optional misaligned-access trap is built in when MEM_MISALIGN_CHK_EN is defined.
module mem_pipe #(
    parameter int TO_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_to_reg_xm,
    input  logic        reg_write_xm,
    input  logic        mem_read_xm,
    input  logic        mem_write_xm,
    input  logic        fp_operation_xm,
    input  logic        branch_xm,
    input  logic [31:0] branch_addr_xm,
    input  logic [31:0] alu_out_xm,
    input  logic [31:0] alu_out_fp_xm,
    input  logic [31:0] mem_data_xm,
    input  logic [31:0] mem_data_fp_xm,
    input  logic [4:0]  rd_addr_xm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic        pc_src_o,
    output logic [31:0] pc_branch_o,
    output logic        mem_to_reg_mw,
    output logic        reg_write_mw,
    output logic        fp_operation_mw,
    output logic [4:0]  rd_addr_mw,
    output logic [31:0] alu_out_mw,
    output logic [31:0] alu_out_fp_mw,
    output logic [31:0] mem_rdata_mw
);
    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          bus_err_r;
    logic          mem_op_s;
    logic          in_err_s;
    logic          misalign_s;
    logic          access_s;
    logic          stall_s;
    logic          advance_s;
    logic          load_done_s;
    logic [31:0]   addr_raw_s;

    assign mem_op_s   = mem_read_xm | mem_write_xm;
    assign in_err_s   = (state_r == ST_ERR);
    assign addr_raw_s = fp_operation_xm ? alu_out_fp_xm : alu_out_xm;
    assign dmem_wdata = fp_operation_xm ? mem_data_fp_xm : mem_data_xm;
    assign dmem_we    = mem_write_xm;

`ifdef MEM_MISALIGN_CHK_EN
    logic misalign_r;

    assign misalign_s = mem_op_s & (addr_raw_s[1:0] != 2'b00);
    assign dmem_addr  = addr_raw_s;
    assign misalign_o = misalign_r;

    // Misalign flag: one-cycle pulse after a trapped access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_s & ~in_err_s;
        end
    end
`else
    assign misalign_s = 1'b0;
    assign dmem_addr  = addr_raw_s & 32'hFFFF_FFFC;
    assign misalign_o = 1'b0;
`endif

    // A real bus access is a memory op that is neither in the error slot nor trapped.
    assign access_s    = mem_op_s & ~in_err_s & ~misalign_s;
    assign stall_s     = access_s & ~dmem_ack;
    assign advance_s   = ~stall_s & ~in_err_s & ~misalign_s;
    assign load_done_s = access_s & dmem_ack & mem_read_xm;

    // Gated with rstn so an access under reset is dropped immediately.
    assign dmem_req    = rstn & access_s;
    assign stall_o     = rstn & stall_s;
    assign bus_err_o   = bus_err_r;
    assign pc_src_o    = branch_xm;
    assign pc_branch_o = branch_addr_xm;

    // FSM state, timeout counter and bus-error flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bus_err_r <= (state_next_s == ST_ERR);
        end
    end

    // Next-state logic: wait for ack, give up after TO_CYC wait cycles
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s && !dmem_ack) begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (!access_s || dmem_ack) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_ERR;
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    state_next_s = ST_WAIT;
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            ST_ERR: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // M/W pipeline register: capture on advance, bubble (no writeback) otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_to_reg_mw   <= 1'b0;
            reg_write_mw    <= 1'b0;
            fp_operation_mw <= 1'b0;
            rd_addr_mw      <= 5'd0;
            alu_out_mw      <= 32'd0;
            alu_out_fp_mw   <= 32'd0;
            mem_rdata_mw    <= 32'd0;
        end else if (advance_s) begin
            mem_to_reg_mw   <= mem_to_reg_xm;
            reg_write_mw    <= reg_write_xm;
            fp_operation_mw <= fp_operation_xm;
            rd_addr_mw      <= rd_addr_xm;
            alu_out_mw      <= alu_out_xm;
            alu_out_fp_mw   <= alu_out_fp_xm;
            if (load_done_s) begin
                mem_rdata_mw <= dmem_rdata;
            end else begin
                mem_rdata_mw <= mem_rdata_mw;
            end
        end else begin
            reg_write_mw  <= 1'b0;
            mem_to_reg_mw <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_pipe.sv
// Self-checking bench for mem_pipe: directed vector table, hand-written corner sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_mem_pipe;
    localparam int TO = 4;
`ifdef MEM_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        mem_to_reg_xm, reg_write_xm, mem_read_xm, mem_write_xm, fp_operation_xm, branch_xm;
    logic [31:0] branch_addr_xm, alu_out_xm, alu_out_fp_xm, mem_data_xm, mem_data_fp_xm;
    logic [4:0]  rd_addr_xm;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_o, bus_err_o, misalign_o, pc_src_o;
    logic [31:0] pc_branch_o;
    logic        mem_to_reg_mw, reg_write_mw, fp_operation_mw;
    logic [4:0]  rd_addr_mw;
    logic [31:0] alu_out_mw, alu_out_fp_mw, mem_rdata_mw;

    mem_pipe #(.TO_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .mem_to_reg_xm(mem_to_reg_xm), .reg_write_xm(reg_write_xm),
        .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
        .fp_operation_xm(fp_operation_xm), .branch_xm(branch_xm),
        .branch_addr_xm(branch_addr_xm), .alu_out_xm(alu_out_xm),
        .alu_out_fp_xm(alu_out_fp_xm), .mem_data_xm(mem_data_xm),
        .mem_data_fp_xm(mem_data_fp_xm), .rd_addr_xm(rd_addr_xm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o),
        .pc_src_o(pc_src_o), .pc_branch_o(pc_branch_o),
        .mem_to_reg_mw(mem_to_reg_mw), .reg_write_mw(reg_write_mw),
        .fp_operation_mw(fp_operation_mw), .rd_addr_mw(rd_addr_mw),
        .alu_out_mw(alu_out_mw), .alu_out_fp_mw(alu_out_fp_mw), .mem_rdata_mw(mem_rdata_mw)
    );

    typedef struct {
        logic mtr, rw, rd, wr, fp, br;
        logic [31:0] baddr, alu, alu_fp, md, md_fp;
        logic [4:0] rd_a;
    } xm_t;

    typedef struct {
        xm_t x;
        logic ack;
        logic [31:0] rdata;
        logic e_req, e_stall;
        logic [31:0] e_addr, e_wdata;
        logic e_rw, e_mtr, e_fp;
        logic [4:0] e_rd;
        logic [31:0] e_alu, e_alufp, e_rdata;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 nop
    function automatic xm_t mk(input int kind, input logic fp, input logic [31:0] alu,
                               input logic [31:0] alu_fp, input logic [31:0] md,
                               input logic [31:0] md_fp, input logic [4:0] rd_a,
                               input logic br, input logic [31:0] baddr);
        xm_t x;
        x.rw = (kind == 0) || (kind == 1);
        x.mtr = (kind == 1);
        x.rd = (kind == 1);
        x.wr = (kind == 2);
        x.fp = fp; x.br = br; x.baddr = baddr;
        x.alu = alu; x.alu_fp = alu_fp; x.md = md; x.md_fp = md_fp; x.rd_a = rd_a;
        return x;
    endfunction

    function automatic vec_t mkv(input xm_t x, input logic ack, input logic [31:0] rdata,
                                 input logic e_req, input logic [31:0] e_addr,
                                 input logic [31:0] e_wdata, input logic e_rw, input logic e_mtr,
                                 input logic e_fp, input logic [4:0] e_rd, input logic [31:0] e_alu,
                                 input logic [31:0] e_alufp, input logic [31:0] e_rdata);
        vec_t v;
        v.x = x; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_stall = 1'b0; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_fp = e_fp; v.e_rd = e_rd;
        v.e_alu = e_alu; v.e_alufp = e_alufp; v.e_rdata = e_rdata;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 5) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic xm_t rand_xm();
        int k;
        k = int'($urandom_range(0, 3));
        return mk(k, 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom());
    endfunction

    task automatic drive(input xm_t x, input logic ack, input logic [31:0] rdata);
        mem_to_reg_xm = x.mtr; reg_write_xm = x.rw; mem_read_xm = x.rd; mem_write_xm = x.wr;
        fp_operation_xm = x.fp; branch_xm = x.br; branch_addr_xm = x.baddr;
        alu_out_xm = x.alu; alu_out_fp_xm = x.alu_fp; mem_data_xm = x.md; mem_data_fp_xm = x.md_fp;
        rd_addr_xm = x.rd_a; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    vec_t vt[6];
    xm_t  nop;
    xm_t  x;

    // behavioural model state
    int          age;
    logic        err_pend, mis_prev, new_mis, hold, mem_op, mis, e_req, e_stall, cur_ack;
    logic [31:0] a, e_addr, cur_rdata;
    logic        m_rw, m_mtr, m_fp;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_alufp, m_rdata;

    initial begin
        nop = mk(3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        vt[0] = mkv(mk(0, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 32'h0), 1'b0, 32'h0,
                    1'b0, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0);
        vt[1] = mkv(mk(1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0), 1'b1, 32'hDEADBEEF,
                    1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h40, 32'h0, 32'hDEADBEEF);
        vt[2] = mkv(mk(1, 1'b1, 32'h999, 32'h100, 32'h11, 32'hAAAA, 5'd3, 1'b0, 32'h0), 1'b1, 32'h3F800000,
                    1'b1, 32'h100, 32'hAAAA, 1'b1, 1'b1, 1'b1, 5'd3, 32'h999, 32'h100, 32'h3F800000);
        vt[3] = mkv(mk(2, 1'b0, 32'h80, 32'h0, 32'h55, 32'h66, 5'd0, 1'b0, 32'h0), 1'b1, 32'hBAD0BAD0,
                    1'b1, 32'h80, 32'h55, 1'b0, 1'b0, 1'b0, 5'd0, 32'h80, 32'h0, 32'h3F800000);
        vt[4] = mkv(mk(0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0, 5'd31, 1'b1, 32'h2000), 1'b1, 32'h12121212,
                    1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 5'd31, 32'h8, 32'h0, 32'h3F800000);
        vt[5] = mkv(mk(0, 1'b1, 32'h10, 32'h40400000, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0), 1'b0, 32'h0,
                    1'b0, 32'h40400000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h10, 32'h40400000, 32'h3F800000);

        // reset state
        drive(nop, 1'b0, 32'h0);
        rstn = 1'b0;
        @(posedge clk); #2;
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_bus_err", bus_err_o, 1'b0);
        chk1("rst_misalign", misalign_o, 1'b0);
        chk1("rst_rw_mw", reg_write_mw, 1'b0);
        chk32("rst_alu_mw", alu_out_mw, 32'h0);
        chk32("rst_rdata_mw", mem_rdata_mw, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // single-cycle vector table
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].x, vt[i].ack, vt[i].rdata);
            @(negedge clk);
            chk1($sformatf("v%0d_req", i), dmem_req, vt[i].e_req);
            chk1($sformatf("v%0d_stall", i), stall_o, vt[i].e_stall);
            chk32($sformatf("v%0d_addr", i), dmem_addr, vt[i].e_addr);
            chk32($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wdata);
            chk1($sformatf("v%0d_we", i), dmem_we, vt[i].x.wr);
            chk1($sformatf("v%0d_pc_src", i), pc_src_o, vt[i].x.br);
            chk32($sformatf("v%0d_pc_branch", i), pc_branch_o, vt[i].x.baddr);
            @(posedge clk); #1;
            chk1($sformatf("v%0d_rw_mw", i), reg_write_mw, vt[i].e_rw);
            chk1($sformatf("v%0d_mtr_mw", i), mem_to_reg_mw, vt[i].e_mtr);
            chk1($sformatf("v%0d_fp_mw", i), fp_operation_mw, vt[i].e_fp);
            chk32($sformatf("v%0d_rd_mw", i), {27'd0, rd_addr_mw}, {27'd0, vt[i].e_rd});
            chk32($sformatf("v%0d_alu_mw", i), alu_out_mw, vt[i].e_alu);
            chk32($sformatf("v%0d_alufp_mw", i), alu_out_fp_mw, vt[i].e_alufp);
            chk32($sformatf("v%0d_rdata_mw", i), mem_rdata_mw, vt[i].e_rdata);
        end

        // store acked on the fourth request cycle
        x = mk(2, 1'b0, 32'h80, 32'h0, 32'h55, 32'h0, 5'd0, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            drive(x, (c == 3), 32'h0);
            @(negedge clk);
            chk1("sw_req", dmem_req, 1'b1);
            chk1("sw_we", dmem_we, 1'b1);
            chk32("sw_wdata", dmem_wdata, 32'h55);
            chk32("sw_addr", dmem_addr, 32'h80);
            chk1("sw_stall", stall_o, (c < 3));
            if (c > 0) chk1("sw_rw_mw", reg_write_mw, 1'b0);
            @(posedge clk); #1;
        end
        drive(nop, 1'b0, 32'h0);
        @(negedge clk);
        chk1("sw_done_req", dmem_req, 1'b0);
        chk1("sw_done_rw_mw", reg_write_mw, 1'b0);
        chk32("sw_done_alu_mw", alu_out_mw, 32'h80);
        @(posedge clk); #1;

        // load never acked: TO+1 request cycles, then one error cycle
        x = mk(1, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 5'd9, 1'b0, 32'h0);
        for (int c = 0; c < TO + 2; c++) begin
            drive(x, 1'b0, 32'hFFFFFFFF);
            @(negedge clk);
            chk1("to_req", dmem_req, (c < TO + 1));
            chk1("to_stall", stall_o, (c < TO + 1));
            chk1("to_bus_err", bus_err_o, (c == TO + 1));
            if (c > 0) chk1("to_rw_mw", reg_write_mw, 1'b0);
            @(posedge clk); #1;
        end
        drive(nop, 1'b0, 32'h0);
        @(negedge clk);
        chk1("to_after_bus_err", bus_err_o, 1'b0);
        chk1("to_after_rw_mw", reg_write_mw, 1'b0);
        chk1("to_after_mtr_mw", mem_to_reg_mw, 1'b0);
        @(posedge clk); #1;
        drive(mk(1, 1'b0, 32'h48, 32'h0, 32'h0, 32'h0, 5'd10, 1'b0, 32'h0), 1'b1, 32'hCAFE0001);
        @(negedge clk);
        chk1("to_next_req", dmem_req, 1'b1);
        chk1("to_next_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        drive(nop, 1'b0, 32'h0);
        @(negedge clk);
        chk32("to_next_rdata_mw", mem_rdata_mw, 32'hCAFE0001);
        chk1("to_next_rw_mw", reg_write_mw, 1'b1);

        // reset asserted while waiting for ack
        @(posedge clk); #1;
        drive(mk(1, 1'b0, 32'h50, 32'h0, 32'h0, 32'h0, 5'd11, 1'b0, 32'h0), 1'b0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rw_wait_stall", stall_o, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk1("rw_req", dmem_req, 1'b0);
        chk1("rw_stall", stall_o, 1'b0);
        chk1("rw_rw_mw", reg_write_mw, 1'b0);
        chk1("rw_mtr_mw", mem_to_reg_mw, 1'b0);
        chk32("rw_alu_mw", alu_out_mw, 32'h0);
        chk32("rw_rdata_mw", mem_rdata_mw, 32'h0);
        chk32("rw_rd_mw", {27'd0, rd_addr_mw}, 32'h0);
        drive(nop, 1'b0, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        drive(mk(1, 1'b0, 32'h54, 32'h0, 32'h0, 32'h0, 5'd12, 1'b0, 32'h0), 1'b0, 32'h0);
        @(negedge clk);
        chk1("rw_post_stall", stall_o, 1'b1);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h2468ACE0;
        @(negedge clk);
        chk1("rw_post_ack_stall", stall_o, 1'b0);
        @(posedge clk); #1;

        // misaligned load at 0x42
        drive(mk(1, 1'b0, 32'h42, 32'h0, 32'h0, 32'h0, 5'd13, 1'b0, 32'h0), 1'b1, 32'h13579BDF);
        @(negedge clk);
        chk1("mis_req", dmem_req, !MIS_EN);
        chk1("mis_stall", stall_o, 1'b0);
        chk32("mis_addr", dmem_addr, MIS_EN ? 32'h42 : 32'h40);
        @(posedge clk); #1;
        drive(nop, 1'b0, 32'h0);
        @(negedge clk);
        chk1("mis_pulse", misalign_o, MIS_EN);
        chk1("mis_rw_mw", reg_write_mw, !MIS_EN);
        chk32("mis_rdata_mw", mem_rdata_mw, MIS_EN ? 32'h2468ACE0 : 32'h13579BDF);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mis_pulse_end", misalign_o, 1'b0);

        // randomized traffic against the behavioural model
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        age = 0; err_pend = 1'b0; mis_prev = 1'b0; hold = 1'b0; x = nop;
        m_rw = 1'b0; m_mtr = 1'b0; m_fp = 1'b0; m_rd = 5'd0;
        m_alu = 32'h0; m_alufp = 32'h0; m_rdata = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) x = rand_xm();
            cur_ack = ($urandom_range(0, 2) == 0);
            cur_rdata = $urandom();
            drive(x, cur_ack, cur_rdata);
            mem_op = x.rd | x.wr;
            a = x.fp ? x.alu_fp : x.alu;
            mis = MIS_EN && mem_op && (a[1:0] != 2'b00);
            e_req = mem_op && !mis && !err_pend;
            e_stall = e_req && !cur_ack;
            e_addr = MIS_EN ? a : (a & 32'hFFFFFFFC);
            @(negedge clk);
            chk1("r_req", dmem_req, e_req);
            chk1("r_stall", stall_o, e_stall);
            chk1("r_we", dmem_we, x.wr);
            chk32("r_addr", dmem_addr, e_addr);
            chk32("r_wdata", dmem_wdata, x.fp ? x.md_fp : x.md);
            chk1("r_pc_src", pc_src_o, x.br);
            chk32("r_pc_branch", pc_branch_o, x.baddr);
            chk1("r_bus_err", bus_err_o, err_pend);
            chk1("r_misalign", misalign_o, mis_prev);
            chk1("r_rw_mw", reg_write_mw, m_rw);
            chk1("r_mtr_mw", mem_to_reg_mw, m_mtr);
            chk1("r_fp_mw", fp_operation_mw, m_fp);
            chk32("r_rd_mw", {27'd0, rd_addr_mw}, {27'd0, m_rd});
            chk32("r_alu_mw", alu_out_mw, m_alu);
            chk32("r_alufp_mw", alu_out_fp_mw, m_alufp);
            chk32("r_rdata_mw", mem_rdata_mw, m_rdata);
            @(posedge clk);
            new_mis = 1'b0;
            if (err_pend) begin
                m_rw = 1'b0; m_mtr = 1'b0; err_pend = 1'b0; age = 0;
            end else if (e_stall) begin
                m_rw = 1'b0; m_mtr = 1'b0; age = age + 1;
                if (age == TO + 1) err_pend = 1'b1;
            end else if (mis) begin
                m_rw = 1'b0; m_mtr = 1'b0; new_mis = 1'b1;
            end else begin
                m_rw = x.rw; m_mtr = x.mtr; m_fp = x.fp; m_rd = x.rd_a;
                m_alu = x.alu; m_alufp = x.alu_fp;
                if (e_req && x.rd) m_rdata = cur_rdata;
                age = 0;
            end
            mis_prev = new_mis;
            hold = e_stall;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
